// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller.
// Holds the register-specifier width, the forward-select encodings,
// the destination-slot record layout and the source-match helpers.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 3;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Destination info tracked per pipeline stage.
  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_reg;
    logic             is_load;
  } slot_t;

  // A source hits a slot only if the slot really writes that register
  // and the instruction actually consumes the source.
  function automatic logic src_match(input slot_t s, input logic [REG_W-1:0] src,
                                     input logic used);
    return s.valid && s.wr_en && (s.wr_reg == src) && used;
  endfunction

  // Newest producer (EX) wins over the older one (MEM).
  function automatic fwd_sel_e fwd_pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return FWD_EXMEM;
    else if (hit_mem) return FWD_MEMWB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// Destination-info pipeline register with hold, clear and async reset.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_hold    - keep current contents (takes priority over clear/load)
//   i_clear   - load an invalid (bubble) record
//   i_d       - record to load
//   o_q       - registered record
module hazard_slot
  import hazard_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_hold,
  input  logic  i_clear,
  input  slot_t i_d,
  output slot_t o_q
);

  slot_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_q <= '0;
    else if (i_hold)  r_q <= r_q;
    else if (i_clear) r_q <= '0;
    else              r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// Shadows destination info of the instructions in EX and MEM, produces
// registered operand forward selects for EX, detects load-use hazards,
// squashes on EX redirect and freezes while data memory is busy.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   id_*                      - decoded fields of the instruction in ID
//   mem_busy                  - data memory stall, whole pipeline frozen
//   ex_redirect               - taken branch/jump resolved in EX
//   fwd_A, fwd_B              - EX operand selects (10 EX/MEM, 01 MEM/WB, 00 RF)
//   stall, bubble, flush      - PC/IF-ID hold, ID/EX NOP, IF/ID squash
//   stall_cnt                 - saturating count of load-use stall cycles
module hazard_ctrl #(
  parameter int unsigned REG_W = hazard_ctrl_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             mem_busy,
  input  logic             ex_redirect,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  import hazard_ctrl_pkg::*;

  slot_t            w_ex_d;
  slot_t            w_ex_q;
  slot_t            w_mem_q;
  logic             w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic             w_luh;
  logic             w_flush;
  logic             w_clear;
  fwd_sel_e         w_sel_a, w_sel_b;
  fwd_sel_e         r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0] r_cnt;
  logic             w_unused_mem_load;

  always_comb begin
    w_ex_d         = '0;
    w_ex_d.valid   = id_valid;
    w_ex_d.wr_en   = id_wr_en;
    w_ex_d.wr_reg  = id_wr_reg;
    w_ex_d.is_load = id_is_load;

    w_rs_ex  = src_match(w_ex_q,  id_rs, id_rs_used);
    w_rt_ex  = src_match(w_ex_q,  id_rt, id_rt_used);
    w_rs_mem = src_match(w_mem_q, id_rs, id_rs_used);
    w_rt_mem = src_match(w_mem_q, id_rt, id_rt_used);

    // Freeze beats redirect, redirect beats load-use.
    w_luh   = !mem_busy && !ex_redirect && id_valid && w_ex_q.is_load &&
              (w_rs_ex || w_rt_ex);
    w_flush = ex_redirect && !mem_busy;
    w_clear = w_flush || w_luh;

    // Unused sources never match, so an unused rt always selects RF.
    w_sel_a = fwd_pick(w_rs_ex, w_rs_mem);
    w_sel_b = fwd_pick(w_rt_ex, w_rt_mem);
  end

  hazard_slot u_ex_slot (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (mem_busy),
    .i_clear (w_clear),
    .i_d     (w_ex_d),
    .o_q     (w_ex_q)
  );

  hazard_slot u_mem_slot (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (mem_busy),
    .i_clear (1'b0),
    .i_d     (w_ex_q),
    .o_q     (w_mem_q)
  );

  // The load flag is only meaningful in EX; MEM keeps it for record symmetry.
  assign w_unused_mem_load = w_mem_q.is_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (!mem_busy) begin
      if (w_clear) begin
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_fwd_a <= w_sel_a;
        r_fwd_b <= w_sel_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cnt <= '0;
    else if (w_luh && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign fwd_A     = r_fwd_a;
  assign fwd_B     = r_fwd_b;
  assign stall     = w_luh;
  assign bubble    = w_luh;
  assign flush     = w_flush;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 0, id_rs_used = 0, id_rt_used = 0, id_wr_en = 0, id_is_load = 0;
  logic [2:0]  id_rs = 0, id_rt = 0, id_wr_reg = 0;
  logic        mem_busy = 0, ex_redirect = 0;
  logic [1:0]  fwd_A, fwd_B;
  logic        stall, bubble, flush;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [2:0] rs;
    logic       rsu;
    logic [2:0] rt;
    logic       rtu;
    logic       we;
    logic [2:0] wr;
    logic       ld;
    logic       busy;
    logic       redir;
    logic [22:0] exp;
  } stim_t;

  typedef struct {
    string       name;
    logic [22:0] val;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl #(.REG_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .mem_busy(mem_busy), .ex_redirect(ex_redirect),
    .fwd_A(fwd_A), .fwd_B(fwd_B), .stall(stall), .bubble(bubble),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [22:0] obs();
    return {fwd_A, fwd_B, stall, bubble, flush, stall_cnt};
  endfunction

  // Expected outputs: fwd of the instruction now in EX, hazard outputs for
  // the ID inputs being driven, and the current stall count.
  function automatic stim_t S(logic v, logic [2:0] rs, logic rsu, logic [2:0] rt,
                              logic rtu, logic we, logic [2:0] wr, logic ld,
                              logic busy, logic redir, logic [1:0] fa, logic [1:0] fb,
                              logic st, logic bb, logic fl, int cnt);
    stim_t s;
    s.v = v; s.rs = rs; s.rsu = rsu; s.rt = rt; s.rtu = rtu; s.we = we;
    s.wr = wr; s.ld = ld; s.busy = busy; s.redir = redir;
    s.exp = {fa, fb, st, bb, fl, 16'(cnt)};
    return s;
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue its expectation.
  task automatic apply(input string name, input stim_t s);
    exp_t e;
    @(negedge clk);
    id_valid = s.v; id_rs = s.rs; id_rs_used = s.rsu; id_rt = s.rt;
    id_rt_used = s.rtu; id_wr_en = s.we; id_wr_reg = s.wr; id_is_load = s.ld;
    mem_busy = s.busy; ex_redirect = s.redir;
    e.name = name; e.val = s.exp;
    sb.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    id_valid = 0; id_rs_used = 0; id_rt_used = 0; id_wr_en = 0; id_is_load = 0;
    mem_busy = 0; ex_redirect = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs() !== 23'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), 23'h0);
    end
    do_reset();
  endtask

  task automatic test_fwd_ex();
    stim_t t[$];
    exp_t e;
    do_reset();
    t.push_back(S(1,1,1,2,1,1,3,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,3,1,5,1,1,4,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(0,0,0,0,0,0,0,0,0,0, 2'b10,2'b00,0,0,0,0));
    foreach (t[i]) begin
      apply("fwd_ex", t[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.val) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), e.val);
      end
    end
  endtask

  task automatic test_fwd_mem();
    stim_t t[$];
    exp_t e;
    for (int u = 1; u >= 0; u--) begin
      do_reset();
      t.delete();
      t.push_back(S(1,1,1,2,1,1,3,0,0,0, 2'b00,2'b00,0,0,0,0));
      t.push_back(S(1,6,1,7,1,1,5,0,0,0, 2'b00,2'b00,0,0,0,0));
      t.push_back(S(1,0,1,3,u[0],1,4,0,0,0, 2'b00,2'b00,0,0,0,0));
      t.push_back(S(0,0,0,0,0,0,0,0,0,0, 2'b00,(u != 0) ? 2'b01 : 2'b00,0,0,0,0));
      foreach (t[i]) begin
        apply((u != 0) ? "fwd_mem_rt" : "fwd_rt_unused", t[i]);
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
          errors++;
          $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), e.val);
        end
      end
    end
  endtask

  task automatic test_newest_wins();
    stim_t t[$];
    exp_t e;
    do_reset();
    t.push_back(S(1,4,1,5,1,1,2,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,4,1,5,1,1,2,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,2,1,2,1,1,7,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(0,0,0,0,0,0,0,0,0,0, 2'b10,2'b10,0,0,0,0));
    foreach (t[i]) begin
      apply("newest_wins", t[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.val) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), e.val);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    exp_t e;
    do_reset();
    t.push_back(S(1,1,1,0,0,1,6,1,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,6,1,2,1,1,7,0,0,0, 2'b00,2'b00,1,1,0,0));
    t.push_back(S(1,6,1,2,1,1,7,0,0,0, 2'b00,2'b00,0,0,0,1));
    t.push_back(S(0,0,0,0,0,0,0,0,0,0, 2'b01,2'b00,0,0,0,1));
    foreach (t[i]) begin
      apply("load_use", t[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.val) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), e.val);
      end
    end
  endtask

  task automatic test_redirect_beats_luh();
    stim_t t[$];
    exp_t e;
    do_reset();
    t.push_back(S(1,1,1,0,0,1,6,1,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,6,1,2,1,1,7,0,0,1, 2'b00,2'b00,0,0,1,0));
    t.push_back(S(1,6,1,2,1,1,7,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(0,0,0,0,0,0,0,0,0,0, 2'b01,2'b00,0,0,0,0));
    foreach (t[i]) begin
      apply("redirect_luh", t[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.val) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), e.val);
      end
    end
  endtask

  task automatic test_mem_busy();
    stim_t t[$];
    exp_t e;
    do_reset();
    t.push_back(S(1,1,1,2,1,1,3,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,3,1,5,1,1,4,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,4,1,3,1,1,6,0,1,0, 2'b10,2'b00,0,0,0,0));
    t.push_back(S(1,4,1,3,1,1,6,0,1,1, 2'b10,2'b00,0,0,0,0));
    t.push_back(S(1,4,1,3,1,1,6,0,1,0, 2'b10,2'b00,0,0,0,0));
    t.push_back(S(1,4,1,3,1,1,6,0,0,0, 2'b10,2'b00,0,0,0,0));
    t.push_back(S(0,0,0,0,0,0,0,0,0,0, 2'b10,2'b01,0,0,0,0));
    foreach (t[i]) begin
      apply("mem_busy", t[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.val) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), e.val);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t t[$];
    exp_t e;
    do_reset();
    t.push_back(S(1,0,0,0,0,1,1,0,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,1,1,0,0,1,6,1,0,0, 2'b00,2'b00,0,0,0,0));
    t.push_back(S(1,6,1,2,1,1,7,0,0,0, 2'b10,2'b00,1,1,0,0));
    foreach (t[i]) begin
      apply("pre_reset", t[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.val) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), e.val);
      end
    end
    // Assert reset between clock edges: outputs must clear without a clock.
    #1 rst = 1'b1;
    e.name = "reset_mid_stall"; e.val = 23'h0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    checks++;
    if (obs() !== e.val) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
    end
    @(negedge clk);
    rst = 1'b0;
    apply("after_reset", S(1,6,1,2,1,1,7,0,0,0, 2'b00,2'b00,0,0,0,0));
    e = sb.pop_front();
    checks++;
    if (obs() !== e.val) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_newest_wins();
    test_load_use();
    test_redirect_beats_luh();
    test_mem_busy();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
